// File: rtl/ahb_slave_arbiter_gen_pkg.sv
// Shared types for the per-slave AHB arbiter: burst encoding, arbitration mode,
// FSM states and the beat-limit lookup.
package ahb_slave_arbiter_gen_pkg;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_type;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Number of beats in a burst; undefined-length INCR is capped at incr_beats.
    function automatic int unsigned burst_beats(input hburst_type burst,
                                                input int unsigned incr_beats);
        int unsigned beats;
        beats = 1;
        case (burst)
            SINGLE:          beats = 1;
            INCR:            beats = incr_beats;
            WRAP4, INCR4:    beats = 4;
            WRAP8, INCR8:    beats = 8;
            WRAP16, INCR16:  beats = 16;
            default:         beats = 1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_slave_arbiter_gen_if.sv
// Request/grant bundle between the master request decode and one slave arbiter.
interface ahb_slave_arbiter_gen_if
    import ahb_slave_arbiter_gen_pkg::*;
#(
    parameter int MASTER_NUM = 2
) ();
    localparam int IDX_W = $clog2(MASTER_NUM);

    logic [MASTER_NUM-1:0] hreq;
    hburst_type            hburst;
    logic                  hwait;
    arb_mode_e             arb_mode;
    logic [MASTER_NUM-1:0] hgrant;
    logic                  hsel;
    logic [IDX_W-1:0]      hmaster;
    logic                  hlast;

    modport master (
        output hreq, hburst, hwait, arb_mode,
        input  hgrant, hsel, hmaster, hlast
    );

    modport slave (
        input  hreq, hburst, hwait, arb_mode,
        output hgrant, hsel, hmaster, hlast
    );
endinterface

// File: rtl/ahb_slave_arbiter_gen_picker.sv
// Combinational winner selection: first requester found scanning upward from
// start_ptr (or from 0 when round-robin is disabled), wrapping at REQ_NUM-1.
module ahb_arb_picker #(
    parameter  int REQ_NUM = 2,
    localparam int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IDX_W-1:0]   start_ptr,
    input  logic               rr_en,
    output logic [REQ_NUM-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    always_comb begin
        int         cand;
        logic [IDX_W-1:0] base;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        base     = rr_en ? start_ptr : '0;
        valid    = 1'b0;
        index    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = int'(base) + i;
            if (cand >= REQ_NUM) begin
                cand = cand - REQ_NUM;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_onehot
            assign winner[gi] = valid && (index == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/ahb_slave_arbiter_gen.sv
// Per-slave AHB arbiter: fixed-priority or round-robin selection, burst beat
// tracking with a cap on undefined-length INCR, registered one-hot grant.
module ahb_slave_arbiter_gen
    import ahb_slave_arbiter_gen_pkg::*;
#(
    parameter int MASTER_NUM     = 2,
    parameter int MAX_INCR_BEATS = 16,
    parameter int RESET_RR_PTR   = 0
) (
    input  logic                    hclk,
    input  logic                    hreset_n,
    ahb_slave_arbiter_gen_if.slave  bus
);

    localparam int IDX_W   = $clog2(MASTER_NUM);
    localparam int CNT_MAX = (MAX_INCR_BEATS > 16) ? MAX_INCR_BEATS : 16;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_e            state_reg, state_next;
    logic [MASTER_NUM-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;
    hburst_type            burst_reg, burst_next;

    logic [MASTER_NUM-1:0] pick_onehot;
    logic [IDX_W-1:0]      pick_index;
    logic                  pick_valid;
    logic                  rr_en;
    logic [IDX_W-1:0]      hmaster_enc;
    logic                  beat_ok;
    logic                  last_beat;
    logic                  arbitrate;
    logic                  new_grant;
    hburst_type            cur_burst;
    int unsigned           beat_limit;
    logic [IDX_W-1:0]      rr_ptr_after;

    assign rr_en = (bus.arb_mode == ARB_RR);

    ahb_arb_picker #(
        .REQ_NUM (MASTER_NUM)
    ) u_picker (
        .req       (bus.hreq),
        .start_ptr (rr_ptr_reg),
        .rr_en     (rr_en),
        .winner    (pick_onehot),
        .index     (pick_index),
        .valid     (pick_valid)
    );

    always_comb begin
        hmaster_enc = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_reg[i]) begin
                hmaster_enc = hmaster_enc | IDX_W'(i);
            end
        end
    end

    // The first beat has not been latched yet, so its limit comes from the live bus.
    assign cur_burst  = (beat_cnt_reg == '0) ? bus.hburst : burst_reg;
    assign beat_limit = burst_beats(cur_burst, MAX_INCR_BEATS);
    assign beat_ok    = (|grant_reg) & ~bus.hwait;

    assign last_beat = (state_reg == ST_BUSY) && beat_ok &&
                       ((32'(beat_cnt_reg) == beat_limit - 1) ||
                        ((cur_burst == INCR) && !bus.hreq[hmaster_enc]));

    assign arbitrate    = (state_reg == ST_IDLE) || last_beat;
    assign new_grant    = arbitrate && pick_valid;
    assign rr_ptr_after = (pick_index == IDX_W'(MASTER_NUM - 1)) ? '0 : pick_index + 1'b1;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        burst_next    = burst_reg;

        if (new_grant && rr_en) begin
            rr_ptr_next = rr_ptr_after;
        end

        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_next    = pick_onehot;
                    state_next    = ST_BUSY;
                    beat_cnt_next = '0;
                end
            end
            ST_BUSY: begin
                if (beat_ok) begin
                    if (beat_cnt_reg == '0) begin
                        burst_next = bus.hburst;
                    end
                    if (last_beat) begin
                        beat_cnt_next = '0;
                        if (pick_valid) begin
                            grant_next = pick_onehot;
                        end else begin
                            grant_next = '0;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= IDX_W'(RESET_RR_PTR);
            beat_cnt_reg <= '0;
            burst_reg    <= SINGLE;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            burst_reg    <= burst_next;
        end
    end

    assign bus.hgrant  = grant_reg;
    assign bus.hsel    = |grant_reg;
    assign bus.hmaster = hmaster_enc;
    assign bus.hlast   = last_beat;

endmodule

// File: tb/tb_ahb_slave_arbiter_gen.sv
// Directed bench for the per-slave arbiter with four masters: fixed and
// round-robin arbitration, stalls, INCR cutoff, async reset, hreq drop.
module tb_ahb_slave_arbiter_gen;
    import ahb_slave_arbiter_gen_pkg::*;

    logic hclk = 1'b0;
    logic hreset_n;
    int   vec_cnt  = 0;
    int   miscmp   = 0;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter_gen_if #(.MASTER_NUM(4)) bus ();

    ahb_slave_arbiter_gen #(
        .MASTER_NUM     (4),
        .MAX_INCR_BEATS (16),
        .RESET_RR_PTR   (0)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] exp_grant, input logic exp_last);
        logic [1:0] exp_master;
        exp_master = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (exp_grant[i]) exp_master = 2'(i);
        end
        $display("%s: hreq=%b hgrant=%b hsel=%b hmaster=%0d hlast=%b",
                 tag, bus.hreq, bus.hgrant, bus.hsel, bus.hmaster, bus.hlast);
        chk({tag, "_hgrant"},  32'(bus.hgrant),  32'(exp_grant));
        chk({tag, "_hsel"},    32'(bus.hsel),    32'(|exp_grant));
        chk({tag, "_hmaster"}, 32'(bus.hmaster), 32'(exp_master));
        chk({tag, "_hlast"},   32'(bus.hlast),   32'(exp_last));
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance one cycle.
    task automatic step(input string tag, input logic [3:0] req, input hburst_type burst,
                        input logic stall, input arb_mode_e mode,
                        input logic [3:0] exp_grant, input logic exp_last);
        bus.hreq     = req;
        bus.hburst   = burst;
        bus.hwait    = stall;
        bus.arb_mode = mode;
        @(negedge hclk);
        chk_bus(tag, exp_grant, exp_last);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset_n     = 1'b0;
        bus.hreq     = 4'b0000;
        bus.hburst   = SINGLE;
        bus.hwait    = 1'b0;
        bus.arb_mode = ARB_FIXED;
        #2;
        chk_bus("reset", 4'b0000, 1'b0);
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;

        // Fixed priority INCR4; master 0 drops on beat 4 so master 1 follows.
        step("t1_idle", 4'b0011, INCR4,  1'b0, ARB_FIXED, 4'b0000, 1'b0);
        step("t1_b1",   4'b0011, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t1_b2",   4'b0011, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t1_b3",   4'b0011, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t1_b4",   4'b0010, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b1);
        step("t1_m1",   4'b0000, SINGLE, 1'b0, ARB_FIXED, 4'b0010, 1'b1);
        step("t1_end",  4'b0000, SINGLE, 1'b0, ARB_FIXED, 4'b0000, 1'b0);

        // Round robin, all SINGLE: order 0,1,2,3,0 without gaps.
        step("t2_idle", 4'b1111, SINGLE, 1'b0, ARB_RR, 4'b0000, 1'b0);
        step("t2_g0",   4'b1111, SINGLE, 1'b0, ARB_RR, 4'b0001, 1'b1);
        step("t2_g1",   4'b1111, SINGLE, 1'b0, ARB_RR, 4'b0010, 1'b1);
        step("t2_g2",   4'b1111, SINGLE, 1'b0, ARB_RR, 4'b0100, 1'b1);
        step("t2_g3",   4'b1111, SINGLE, 1'b0, ARB_RR, 4'b1000, 1'b1);
        step("t2_g0b",  4'b0000, SINGLE, 1'b0, ARB_RR, 4'b0001, 1'b1);
        step("t2_end",  4'b0000, SINGLE, 1'b0, ARB_RR, 4'b0000, 1'b0);

        // INCR8 with stalls on beats 3 and 6; hburst changes after beat 1 are ignored.
        step("t3_idle", 4'b0001, INCR8,  1'b0, ARB_FIXED, 4'b0000, 1'b0);
        step("t3_b1",   4'b0001, INCR8,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b2",   4'b0001, INCR8,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_w3",   4'b0001, INCR8,  1'b1, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b3",   4'b0001, INCR8,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b4",   4'b0001, SINGLE, 1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b5",   4'b0001, SINGLE, 1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_w6",   4'b0001, SINGLE, 1'b1, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b6",   4'b0001, SINGLE, 1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b7",   4'b0001, SINGLE, 1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t3_b8",   4'b0000, SINGLE, 1'b0, ARB_FIXED, 4'b0001, 1'b1);
        step("t3_end",  4'b0000, SINGLE, 1'b0, ARB_FIXED, 4'b0000, 1'b0);

        // INCR: forced cutoff at 16 beats, re-grant, then early end after 5 beats.
        step("t4_idle", 4'b0001, INCR, 1'b0, ARB_FIXED, 4'b0000, 1'b0);
        for (int i = 1; i <= 15; i++)
            step($sformatf("t4_a%0d", i), 4'b0001, INCR, 1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t4_a16",  4'b0001, INCR, 1'b0, ARB_FIXED, 4'b0001, 1'b1);
        for (int i = 1; i <= 4; i++)
            step($sformatf("t4_b%0d", i), 4'b0001, INCR, 1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t4_b5",   4'b0000, INCR, 1'b0, ARB_FIXED, 4'b0001, 1'b1);
        step("t4_end",  4'b0000, INCR, 1'b0, ARB_FIXED, 4'b0000, 1'b0);

        // Async reset mid-WRAP16; round-robin pointer must return to 0.
        step("t5_idle", 4'b0100, WRAP16, 1'b0, ARB_RR, 4'b0000, 1'b0);
        for (int i = 1; i <= 6; i++)
            step($sformatf("t5_b%0d", i), 4'b0100, WRAP16, 1'b0, ARB_RR, 4'b0100, 1'b0);
        #1;
        chk_bus("t5_b7", 4'b0100, 1'b0);
        hreset_n = 1'b0;
        #1;
        chk_bus("t5_async", 4'b0000, 1'b0);
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        step("t5_rearb", 4'b1111, SINGLE, 1'b0, ARB_RR, 4'b0000, 1'b0);
        step("t5_g0",    4'b0000, SINGLE, 1'b0, ARB_RR, 4'b0001, 1'b1);
        step("t5_end",   4'b0000, SINGLE, 1'b0, ARB_RR, 4'b0000, 1'b0);

        // Master 0 drops hreq on INCR4 beat 2; burst still runs 4 beats, last one stalled once.
        step("t6_idle", 4'b0011, INCR4,  1'b0, ARB_FIXED, 4'b0000, 1'b0);
        step("t6_b1",   4'b0011, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t6_b2",   4'b0010, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t6_b3",   4'b0010, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b0);
        step("t6_w4",   4'b0010, INCR4,  1'b1, ARB_FIXED, 4'b0001, 1'b0);
        step("t6_b4",   4'b0010, INCR4,  1'b0, ARB_FIXED, 4'b0001, 1'b1);
        step("t6_m1",   4'b0000, SINGLE, 1'b0, ARB_FIXED, 4'b0010, 1'b1);
        step("t6_end",  4'b0000, SINGLE, 1'b0, ARB_FIXED, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
